// File: rtl/trace_axis_packer.sv
// trace_axis_packer: packs narrow valid-yumi trace words into AXI-Stream beats
// Each beat carries {seq[15:0], cnt[7:0], pad, word slots}; partial beats end in tlast.
module trace_axis_packer #(
    parameter int in_width_p      = 80,
    parameter int axis_width_p    = 512,
    parameter int flush_timeout_p = 256,
    localparam int words_per_beat_lp = (axis_width_p - 32) / in_width_p
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    v_i,
    input  logic [in_width_p-1:0]   data_i,
    output logic                    yumi_o,
    input  logic                    flush_i,
    output logic                    m_axis_tvalid_o,
    output logic [axis_width_p-1:0] m_axis_tdata_o,
    output logic                    m_axis_tlast_o,
    input  logic                    m_axis_tready_i
);

    localparam int W      = words_per_beat_lp;
    localparam int BUF_W  = W * in_width_p;
    localparam int PAD_W  = axis_width_p - 24 - BUF_W;
    localparam int CNT_W  = $clog2(W + 1);
    localparam int IDLE_W = $clog2(flush_timeout_p + 1);

    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic [15:0]       r_seq;
    logic [IDLE_W-1:0] r_idle;
    logic              r_flush_pend;

    logic              w_slot_free;
    logic              w_cnt_full;
    logic              w_cnt_zero;
    logic              w_timeout;
    logic              w_flush_req;
    logic              w_transfer;
    logic [31:0]       w_wr_ofs;

    assign w_slot_free = ~m_axis_tvalid_o | m_axis_tready_i;
    assign w_cnt_full  = (r_cnt == CNT_W'(W));
    assign w_cnt_zero  = (r_cnt == '0);
    // The idle count lags one cycle behind the accept, so the threshold
    // includes the current cycle to land the flush exactly timeout cycles
    // after the last accepted word.
    assign w_timeout   = ~w_cnt_zero
                       & (r_idle >= IDLE_W'(flush_timeout_p - 1));
    assign w_flush_req = flush_i | r_flush_pend | w_timeout;
    assign w_transfer  = w_slot_free
                       & (w_cnt_full | (w_flush_req & ~w_cnt_zero));
    assign yumi_o      = v_i & ~reset_i & (~w_cnt_full | w_transfer);
    assign w_wr_ofs    = 32'(r_cnt) * 32'(in_width_p);

    // Accumulator slots; a transfer clears unused slots and may start the next beat
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_buf <= '0;
        end else if (w_transfer) begin
            r_buf <= '0;
            if (yumi_o) r_buf[0 +: in_width_p] <= data_i;
        end else if (yumi_o) begin
            r_buf[w_wr_ofs +: in_width_p] <= data_i;
        end
    end

    // Word count and beat sequence number
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
            r_seq <= '0;
        end else if (w_transfer) begin
            r_cnt <= yumi_o ? CNT_W'(1) : '0;
            r_seq <= r_seq + 16'd1;
        end else if (yumi_o) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Idle counter for the automatic flush, saturating at the timeout
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_idle <= '0;
        end else if (yumi_o | w_transfer | w_cnt_zero) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(flush_timeout_p)) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // Remember a flush that could not be serviced while the output was blocked
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_flush_pend <= 1'b0;
        end else if (w_transfer | w_cnt_zero) begin
            r_flush_pend <= 1'b0;
        end else if (flush_i) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Single-entry output register, held stable while stalled
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_axis_tvalid_o <= 1'b0;
            m_axis_tdata_o  <= '0;
            m_axis_tlast_o  <= 1'b0;
        end else if (w_transfer) begin
            m_axis_tvalid_o <= 1'b1;
            m_axis_tdata_o  <= {r_seq, 8'(r_cnt), {PAD_W{1'b0}}, r_buf};
            m_axis_tlast_o  <= ~w_cnt_full;
        end else if (m_axis_tready_i) begin
            m_axis_tvalid_o <= 1'b0;
        end
    end

endmodule
